// File: rtl/hex_word_sender_pkg.sv
// Shared constants for the hex word sender:
// ASCII control codes, state encoding and counter sizing.
package hex_word_sender_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DIGIT = 2'd1;
  localparam state_t ST_CR    = 2'd2;
  localparam state_t ST_LF    = 2'd3;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  // A single-digit word still needs a 1-bit counter.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_word_sender_binary_to_hex.sv
// Binary_to_hex: one nibble to its uppercase ASCII
// hex digit, as a 7-bit code.
module hex_word_sender_binary_to_hex (
  input  logic [3:0] nibble,
  output logic [6:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 7'h30 + {3'b000, nibble};
    end else begin
      ascii = 7'h37 + {3'b000, nibble};
    end
  end

endmodule

// File: rtl/hex_word_sender.sv
// Prints a binary word as uppercase ASCII hex,
// MSB nibble first, optionally followed by CR LF.
module hex_word_sender
  import hex_word_sender_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit NEWLINE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = cnt_width(DIGITS);

  localparam logic [CW-1:0] CNT_LOAD = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("hex_word_sender: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [6:0]       hex_ascii;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= ASCII_NUL;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (out_ready) begin
          shreg_d = shreg_q << 4;
          if (cnt_q == '0) begin
            state_d = NEWLINE ? ST_CR : ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_CR: begin
        if (out_ready) state_d = ST_LF;
      end
      ST_LF: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are precomputed from next-state so they land
  // in flops together with the state they describe.
  hex_word_sender_binary_to_hex u_b2h (
    .nibble (shreg_d[WIDTH-1 -: 4]),
    .ascii  (hex_ascii)
  );

  always_comb begin
    out_valid_d = (state_d != ST_IDLE);
    out_data_d  = ASCII_NUL;
    case (state_d)
      ST_DIGIT: out_data_d = {1'b0, hex_ascii};
      ST_CR:    out_data_d = ASCII_CR;
      ST_LF:    out_data_d = ASCII_LF;
      default:  out_data_d = ASCII_NUL;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
